// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - XLEN / RAW       : default datapath and register-address widths
//   - alu_sel_e        : ALU function codes driven on aluOutSel (0..8)
//   - issue_state_e    : output-register state (EMPTY / FULL)
//   - opcode, funct3 and funct7 constants for the supported RV32I subset
//   - f3_to_sel()      : funct3 -> function code for OP / OP-IMM
package alu_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8
    } alu_sel_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    function automatic alu_sel_e f3_to_sel(input logic [2:0] f3);
        alu_sel_e sel;
        case (f3)
            F3_ADD:  sel = ALU_ADD;
            F3_SLL:  sel = ALU_SLL;
            F3_SLT:  sel = ALU_SLT;
            F3_SLTU: sel = ALU_SLTU;
            F3_XOR:  sel = ALU_XOR;
            F3_SRL:  sel = ALU_SRL;
            F3_OR:   sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: purely combinational decode of one RV32I instruction.
// Ports:
//   instr   in   32    raw instruction word
//   rs1     in   XLEN  rs1 data (already bypassed by the caller)
//   rs2     in   XLEN  rs2 data (already bypassed by the caller)
//   op_a    out  XLEN  ALU operand A
//   op_b    out  XLEN  ALU operand B
//   sel     out  4     ALU function code
//   rd      out  RAW   destination register
//   illegal out  1     instruction is outside the supported subset
module alu_issue_dec #(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int RAW  = alu_pkg::RAW
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [3:0]      sel,
    output logic [RAW-1:0]  rd,
    output logic            illegal
);
    import alu_pkg::*;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_shift;
    logic       unused_rs1_field;

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRL);
    assign rd       = RAW'(instr[11:7]);

    // The rs1 address is only consumed by the bypass logic in the top level.
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        op_a    = rs1;
        op_b    = rs2;
        sel     = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (is_shift) op_b = XLEN'(rs2[4:0]);
                if (f7 == F7_SUB && f3 == F3_ADD) sel = ALU_SUB;
                else if (f7 == F7_ZERO)           sel = f3_to_sel(f3);
                else                              illegal = 1'b1;  // incl. SRA
            end
            OPC_OP_IMM: begin
                sel = f3_to_sel(f3);
                if (is_shift) begin
                    op_b = XLEN'(instr[24:20]);
                    // funct7 must be zero: SRAI and malformed shifts are rejected
                    if (f7 != F7_ZERO) illegal = 1'b1;
                end else begin
                    op_b = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_LUI: begin
                op_a = '0;
                op_b = XLEN'($signed({instr[31:12], 12'b0}));
                sel  = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue stage in front of the combinational ALU.
// Accepts one instruction per cycle, decodes it, and holds the operands in a
// valid/ready output register.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until that edge, and
// ready may depend combinationally on the consumer's ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          instruction handshake (in_ready combinational)
//   in_instr, rs1_data, rs2_data  instruction and register-file read data
//   flush                      kill held and incoming instruction
//   out_valid/out_ready        operand handshake towards the ALU
//   opA, opB, aluOutSel, out_rd   held operands, function code, destination
//   alu_result                 ALU output for the held instruction (bypass)
//   illegal                    one-cycle pulse after accepting an unsupported op
//   state                      debug view of the output-register state
// Optional feature: define ALU_ISSUE_FWD_EN to enable the operand bypass.
module alu_issue #(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int RAW  = alu_pkg::RAW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       opA,
    output logic [XLEN-1:0]       opB,
    output logic [3:0]            aluOutSel,
    output logic [RAW-1:0]        out_rd,
    input  logic [XLEN-1:0]       alu_result,
    output logic                  illegal,
    output alu_pkg::issue_state_e state
);
    import alu_pkg::*;

    issue_state_e    state_q, state_d;
    logic            load;
    logic            illegal_d;
    logic            accept;
    logic [XLEN-1:0] src1, src2;
    logic [XLEN-1:0] dec_op_a, dec_op_b;
    logic [3:0]      dec_sel;
    logic [RAW-1:0]  dec_rd;
    logic            dec_illegal;

    assign out_valid = (state_q == ST_FULL);
    assign state     = state_q;
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

`ifdef ALU_ISSUE_FWD_EN
    logic [RAW-1:0]  rs1_addr, rs2_addr;
    logic            live_ok;
    logic            byp_valid;
    logic [RAW-1:0]  byp_rd;
    logic [XLEN-1:0] byp_data;

    assign rs1_addr = RAW'(in_instr[19:15]);
    assign rs2_addr = RAW'(in_instr[24:20]);
    // The held instruction's result is on alu_result during its handshake.
    assign live_ok  = out_valid && out_ready && (out_rd != '0);

    // Non-register operands (OP-IMM rs2, LUI rs1) ignore src* in the decoder,
    // so bypassing both unconditionally is safe.
    always_comb begin
        src1 = rs1_data;
        src2 = rs2_data;
        if (live_ok && out_rd == rs1_addr)          src1 = alu_result;
        else if (byp_valid && byp_rd == rs1_addr)   src1 = byp_data;
        if (live_ok && out_rd == rs2_addr)          src2 = alu_result;
        else if (byp_valid && byp_rd == rs2_addr)   src2 = byp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_valid <= 1'b0;
            byp_rd    <= '0;
            byp_data  <= '0;
        end else if (flush) begin
            byp_valid <= 1'b0;
        end else if (live_ok) begin
            byp_valid <= 1'b1;
            byp_rd    <= out_rd;
            byp_data  <= alu_result;
        end
    end
`else
    logic unused_alu_result;

    assign unused_alu_result = ^alu_result;
    assign src1 = rs1_data;
    assign src2 = rs2_data;
`endif

    alu_issue_dec #(.XLEN(XLEN), .RAW(RAW)) u_dec (
        .instr   (in_instr),
        .rs1     (src1),
        .rs2     (src2),
        .op_a    (dec_op_a),
        .op_b    (dec_op_b),
        .sel     (dec_sel),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        illegal_d = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            illegal_d = accept && dec_illegal;
            if (accept && !dec_illegal) begin
                state_d = ST_FULL;
                load    = 1'b1;
            end else if (out_ready) begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            illegal   <= 1'b0;
            opA       <= '0;
            opB       <= '0;
            aluOutSel <= '0;
            out_rd    <= '0;
        end else begin
            state_q <= state_d;
            illegal <= illegal_d;
            if (load) begin
                opA       <= dec_op_a;
                opB       <= dec_op_b;
                aluOutSel <= dec_sel;
                out_rd    <= dec_rd;
            end
        end
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Single-entry issue stage directly upstream of the ALU. Accepts one RV32I integer instruction per cycle with its register-file read data, decodes it into `opA`, `opB` and `aluOutSel`, and holds the result in a valid/ready output register that drives the combinational ALU. It also provides flush, illegal-instruction reporting and an optional one-deep result bypass.

## Interface
- `XLEN`, 32: datapath width.
- `RAW`, 5: register address width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  raw instruction word.
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data for `in_instr[19:15]` / `[24:20]`.
- `flush`  in  1  synchronous kill of held and incoming instruction.
- `out_valid`  out  1  operands valid to ALU.
- `out_ready`  in  1  downstream consumes ALU result.
- `opA`, `opB`  out  XLEN  ALU operands.
- `aluOutSel`  out  4  ALU function code.
- `out_rd`  out  RAW  destination register.
- `alu_result`  in  XLEN  ALU output for held instruction (used only with bypass).
- `illegal`  out  1  one-cycle pulse: accepted instruction not supported.

## Operation
- Function codes: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLT 5, SLTU 6, SLL 7, SRL 8.
- OP (0110011): funct3 000 → ADD, or SUB if funct7 = 0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (funct7 = 0); 110 OR; 111 AND. `opA` = rs1, `opB` = rs2. For shifts, `opB` = zero-extended `rs2[4:0]`.
- OP-IMM (0010011): same funct3 map, never SUB. `opB` = sign-extended `instr[31:20]`. For shifts, `opB` = zero-extended `instr[24:20]`, and `instr[31:25]` must be 0.
- LUI (0110111): `opA` = 0, `opB` = `{instr[31:12], 12'b0}`, ADD.
- Everything else is illegal, including SRA/SRAI, AUIPC and non-zero funct7 on OP apart from SUB. Illegal instructions:
  - are still consumed (handshake completes);
  - pulse `illegal` the next cycle;
  - never set `out_valid`.
- `out_rd` = `instr[11:7]`. rd = 0 is issued normally.
- Output register states EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
  - EMPTY → FULL on a legal accept.
  - FULL → EMPTY on `out_ready` with no accept.
  - FULL → FULL on `out_ready` plus accept (back-to-back).
- `in_ready` = `!flush && (!out_valid || out_ready)`. This is combinational and evaluates to 1 out of reset.
- Flush has priority over everything:
  - next cycle `out_valid` = 0;
  - the incoming instruction is dropped and `illegal` does not pulse;
  - the bypass entry is invalidated.
- Outputs hold stable while `out_valid && !out_ready`.

## Timing
- Latency: accept in cycle N → `out_valid`/operands at N+1.
- Throughput: 1 per cycle when `out_ready` is held high.
- Reset (async assert, sync-safe deassert):
  - `out_valid`, `illegal` = 0;
  - `opA`, `opB`, `aluOutSel`, `out_rd` = 0;
  - bypass entry invalid.
- Reset mid-operation discards the held instruction with no output handshake.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: operand bypass.
  - Live path: when `out_valid && out_ready` and the held `out_rd` ≠ 0 matches the incoming rs1/rs2, `alu_result` replaces the register data.
  - Registered path: otherwise a registered entry (rd, data, valid), captured at each output handshake with rd ≠ 0, replaces the data on a match.
  - Live beats registered.
  - Bypass applies to an operand only where that operand comes from a register.
- Undefined: `rs1_data`/`rs2_data` are used unmodified, `alu_result` is ignored, and no bypass registers exist.

## Structure
- `alu_pkg`: `XLEN`/`RAW` defaults, `aluOutSel` enum codes 0–8, opcode and funct3/funct7 constants.
- Sub-module `alu_issue_dec`: purely combinational decode of `instr` and register data into `opA`, `opB`, sel, rd and illegal. The top level holds the handshake, flush and bypass.

## Test plan
- ADDI x1, x0, -5 with `out_ready` = 1 → next cycle `opA` = 0, `opB` = 0xFFFFFFFB, sel = 0, `out_rd` = 1.
- SUB with rs1 = 10, rs2 = 3 → sel = 1, `opA` = 10, `opB` = 3. SLLI shamt 31 → `opB` = 31, sel = 7. SLL with rs2 = 0x45 → `opB` = 5.
- SRAI (funct7 = 0100000, funct3 = 101) → `illegal` pulses once, `out_valid` stays 0, `in_ready` stays 1.
- `out_ready` = 0 for 3 cycles while FULL → `in_ready` = 0 and outputs stable. Release → back-to-back issue with no bubble.
- `flush` while FULL with `in_valid` = 1 → next cycle `out_valid` = 0, no `illegal` pulse. Assert `rst_n` = 0 mid-stall → all outputs 0 immediately.
- (FWD_EN) ADD x5 issued with `alu_result` = 0x1234 and accepted, then ADD x6, x5, x5 accepted the same cycle → `opA` = `opB` = 0x1234 despite stale `rs1_data`. Same test with rd = x0 → no bypass.
